// File: rtl/gpu_cmd_pkg.sv
// Shared GPU sprite command word layout and helpers used by the command
// scheduler and the sprite input decoder.
package gpu_cmd_pkg;

   localparam int CMD_W   = 35;
   localparam int OP_MSB  = 34;
   localparam int OP_LSB  = 31;
   localparam int IDX_MSB = 30;
   localparam int IDX_LSB = 23;
   localparam int PAY_MSB = 22;
   localparam int DATA_W  = 27;

   localparam logic [3:0] OP_NOP = 4'd0;

   typedef enum logic {
      RR_HOST = 1'b0,
      RR_ANIM = 1'b1
   } rrSel_t;

   function automatic logic [3:0] cmdOpcode(input logic [CMD_W-1:0] cmd);
      return cmd[OP_MSB:OP_LSB];
   endfunction

   function automatic logic isNop(input logic [CMD_W-1:0] cmd);
      return cmdOpcode(cmd) == OP_NOP;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Single-clock synchronous FIFO with occupancy count and synchronous clear.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module cmd_fifo #(
   parameter int DEPTH  = 16,
   parameter int WIDTH  = 35,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty
);

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wrPtr;
   logic [ADDR_W-1:0] rdPtr;
   logic              doPush;
   logic              doPop;

   assign full   = (count == FULL_COUNT);
   assign empty  = (count == '0);
   assign doPush = push & ~full & ~clear;
   assign doPop  = pop & ~empty & ~clear;
   assign dout   = mem[rdPtr];

   // Storage array; contents are don't-care after reset or clear.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= din;
      end
   end

   // Pointers wrap modulo DEPTH; count is kept separately to tell full from empty.
   always_ff @(posedge clk) begin
      if (!rstN || clear) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + ADDR_W'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + ADDR_W'(1);
         end
         case ({doPush, doPop})
            2'b10:   count <= count + (ADDR_W + 1)'(1);
            2'b01:   count <= count - (ADDR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sprite_command_scheduler.sv
// Round-robin merge of host and animation sprite commands into a FIFO that
// drains into the sprite decoder only during vertical blanking.
module sprite_command_scheduler
   import gpu_cmd_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              Clk,
   input  logic              ResetN,
   input  logic [CMD_W-1:0]  HostData,
   input  logic              HostValid,
   output logic              HostReady,
   input  logic [CMD_W-1:0]  AnimData,
   input  logic              AnimValid,
   output logic              AnimReady,
   input  logic              VBlank,
   input  logic              Flush,
   output logic [CMD_W-1:0]  DecodeData,
   output logic [ADDR_W:0]   Count,
   output logic              Busy
);

   logic              fifoFull;
   logic              fifoEmpty;
   logic [CMD_W-1:0]  fifoDout;
   rrSel_t            rrPtr;
   logic              hostElig;
   logic              animElig;
   logic              contend;
   logic              grantHost;
   logic              grantAnim;
   logic              pushEn;
   logic              popEn;
   logic [CMD_W-1:0]  grantWord;

   // Arbitration, no-op filtering and drain gating; full uses the pre-pop count.
   always_comb begin
      hostElig = ResetN & HostValid & ~fifoFull & ~Flush;
      animElig = ResetN & AnimValid & ~fifoFull & ~Flush;
      contend  = hostElig & animElig;
      if (contend) begin
         grantHost = (rrPtr == RR_HOST);
         grantAnim = (rrPtr == RR_ANIM);
      end else begin
         grantHost = hostElig;
         grantAnim = animElig;
      end
      if (grantHost) begin
         grantWord = HostData;
      end else begin
         grantWord = AnimData;
      end
      pushEn = (grantHost | grantAnim) & ~isNop(grantWord);
      popEn  = ResetN & VBlank & ~fifoEmpty & ~Flush;
   end

   assign HostReady = grantHost;
   assign AnimReady = grantAnim;
   assign Busy      = (Count != '0);

   cmd_fifo #(
      .DEPTH  (DEPTH),
      .WIDTH  (CMD_W),
      .ADDR_W (ADDR_W)
   ) uFifo (
      .clk   (Clk),
      .rstN  (ResetN),
      .clear (Flush),
      .push  (pushEn),
      .pop   (popEn),
      .din   (grantWord),
      .dout  (fifoDout),
      .count (Count),
      .full  (fifoFull),
      .empty (fifoEmpty)
   );

   // Round-robin pointer moves only when both requesters competed.
   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         rrPtr <= RR_HOST;
      end else if (contend) begin
         rrPtr <= grantHost ? RR_ANIM : RR_HOST;
      end else begin
         rrPtr <= rrPtr;
      end
   end

   // Decoder bus carries the popped word for one cycle, otherwise the no-op word.
   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         DecodeData <= '0;
      end else if (popEn) begin
         DecodeData <= fifoDout;
      end else begin
         DecodeData <= '0;
      end
   end

endmodule

// File: tb/tb_sprite_command_scheduler.sv
// Self-checking bench for sprite_command_scheduler: a directed vector table,
// hand-written corner sequences and randomized traffic against a queue model.
module tb_sprite_command_scheduler;

   logic        Clk;
   logic        ResetN;
   logic [34:0] HostData;
   logic        HostValid;
   logic        HostReady;
   logic [34:0] AnimData;
   logic        AnimValid;
   logic        AnimReady;
   logic        VBlank;
   logic        Flush;
   logic [34:0] DecodeData;
   logic [4:0]  Count;
   logic        Busy;

   sprite_command_scheduler #(.DEPTH(16), .ADDR_W(4)) dut (
      .Clk        (Clk),
      .ResetN     (ResetN),
      .HostData   (HostData),
      .HostValid  (HostValid),
      .HostReady  (HostReady),
      .AnimData   (AnimData),
      .AnimValid  (AnimValid),
      .AnimReady  (AnimReady),
      .VBlank     (VBlank),
      .Flush      (Flush),
      .DecodeData (DecodeData),
      .Count      (Count),
      .Busy       (Busy)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct {
      logic        rstN;
      logic        hv;
      logic [34:0] hd;
      logic        av;
      logic [34:0] ad;
      logic        vb;
      logic        fl;
      logic        ehr;
      logic        ear;
      logic [34:0] edec;
      logic [4:0]  ecnt;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Reference model: command queue, arbitration preference, last decoder word.
   logic [34:0] q[$];
   bit          preferAnim = 1'b0;
   logic [34:0] mDec = '0;

   function automatic logic [34:0] mk(input logic [3:0] op, input logic [7:0] idx,
                                      input logic [22:0] pay);
      return {op, idx, pay};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic setIn(input logic r, input logic hv, input logic [34:0] hd,
                        input logic av, input logic [34:0] ad, input logic vb, input logic fl);
      ResetN = r; HostValid = hv; HostData = hd;
      AnimValid = av; AnimData = ad; VBlank = vb; Flush = fl;
   endtask

   // Who the model grants this cycle, given the current inputs.
   task automatic modelPre(output bit gh, output bit ga, output bit both);
      bit room, hWants, aWants;
      room   = (q.size() < 16);
      hWants = ResetN && HostValid && room && !Flush;
      aWants = ResetN && AnimValid && room && !Flush;
      both   = hWants && aWants;
      gh = 1'b0;
      ga = 1'b0;
      if (both) begin
         if (preferAnim) ga = 1'b1;
         else gh = 1'b1;
      end else begin
         gh = hWants;
         ga = aWants;
      end
   endtask

   task automatic modelPost(input bit gh, input bit ga, input bit both);
      if (!ResetN) begin
         q.delete();
         preferAnim = 1'b0;
         mDec = '0;
      end else if (Flush) begin
         q.delete();
         mDec = '0;
      end else begin
         if (VBlank && q.size() > 0) mDec = q.pop_front();
         else mDec = '0;
         if (gh && HostData[34:31] != 4'd0) q.push_back(HostData);
         if (ga && AnimData[34:31] != 4'd0) q.push_back(AnimData);
         if (both) preferAnim = !preferAnim;
      end
   endtask

   // One clock: readies checked before the edge, registered outputs after it.
   task automatic cycle(input bit useTbl, input vec_t v, output bit gh, output bit ga,
                        output logic hrAct, output logic arAct);
      bit both;
      #2;
      modelPre(gh, ga, both);
      hrAct = HostReady;
      arAct = AnimReady;
      check("HostReady", HostReady, useTbl ? v.ehr : gh);
      check("AnimReady", AnimReady, useTbl ? v.ear : ga);
      @(posedge Clk);
      modelPost(gh, ga, both);
      #1;
      check("DecodeData", DecodeData, useTbl ? v.edec : mDec);
      check("Count", Count, useTbl ? v.ecnt : 5'(q.size()));
      check("Busy", Busy, useTbl ? (v.ecnt != 5'd0) : (q.size() != 0));
   endtask

   vec_t        tbl[12];
   vec_t        dummy;
   bit          gh, ga;
   logic        hrA, arA;
   logic [34:0] w1, w2, w3, w4, w5, w6, nopw;

   task automatic run(input bit useTbl, input vec_t v);
      cycle(useTbl, v, gh, ga, hrA, arA);
   endtask

   task automatic doReset();
      setIn(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      run(1'b0, dummy);
      run(1'b0, dummy);
   endtask

   initial begin
      logic [34:0] hw[3];
      logic [34:0] aw[3];
      logic [34:0] ord[6];
      logic [34:0] gw[4];
      logic [34:0] pushed[$];
      logic [34:0] popped[$];
      int hi, ai;

      w1   = mk(4'h2, 8'd5, 23'h001234);
      nopw = mk(4'h0, 8'd9, 23'h000007);
      w2   = mk(4'h1, 8'd3, 23'h000055);
      w3   = mk(4'h3, 8'd1, 23'h000111);
      w4   = mk(4'h4, 8'd2, 23'h000222);
      w5   = mk(4'h5, 8'd7, 23'h000333);
      w6   = mk(4'h6, 8'd8, 23'h000444);
      dummy = '{1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 5'd0};

      // rstN hv hd av ad vb fl | HostReady AnimReady DecodeData Count
      tbl[0]  = '{1'b0, 1'b1, w1,   1'b1, w4, 1'b0, 1'b0, 1'b0, 1'b0, 35'd0, 5'd0};
      tbl[1]  = '{1'b0, 1'b1, w1,   1'b1, w4, 1'b0, 1'b0, 1'b0, 1'b0, 35'd0, 5'd0};
      tbl[2]  = '{1'b0, 1'b1, w1,   1'b1, w4, 1'b0, 1'b0, 1'b0, 1'b0, 35'd0, 5'd0};
      tbl[3]  = '{1'b1, 1'b1, w1,   1'b0, w4, 1'b0, 1'b0, 1'b1, 1'b0, 35'd0, 5'd1};
      tbl[4]  = '{1'b1, 1'b1, nopw, 1'b0, w4, 1'b1, 1'b0, 1'b1, 1'b0, w1,    5'd0};
      tbl[5]  = '{1'b1, 1'b1, w2,   1'b0, w4, 1'b1, 1'b0, 1'b1, 1'b0, 35'd0, 5'd1};
      tbl[6]  = '{1'b1, 1'b0, w2,   1'b0, w4, 1'b1, 1'b0, 1'b0, 1'b0, w2,    5'd0};
      tbl[7]  = '{1'b1, 1'b1, w3,   1'b1, w4, 1'b0, 1'b0, 1'b1, 1'b0, 35'd0, 5'd1};
      tbl[8]  = '{1'b1, 1'b1, w5,   1'b1, w4, 1'b0, 1'b0, 1'b0, 1'b1, 35'd0, 5'd2};
      tbl[9]  = '{1'b1, 1'b0, w5,   1'b1, w6, 1'b1, 1'b0, 1'b0, 1'b1, w3,    5'd2};
      tbl[10] = '{1'b1, 1'b0, w5,   1'b1, w6, 1'b1, 1'b1, 1'b0, 1'b0, 35'd0, 5'd0};
      tbl[11] = '{1'b1, 1'b1, w5,   1'b0, w6, 1'b1, 1'b0, 1'b1, 1'b0, 35'd0, 5'd1};

      foreach (tbl[i]) begin
         setIn(tbl[i].rstN, tbl[i].hv, tbl[i].hd, tbl[i].av, tbl[i].ad, tbl[i].vb, tbl[i].fl);
         run(1'b1, tbl[i]);
      end

      // Round-robin: both requesters hold their next word until granted.
      doReset();
      for (int k = 0; k < 3; k++) begin
         hw[k] = mk(4'h8, 8'(k), 23'h010000 + 23'(k));
         aw[k] = mk(4'h9, 8'(k + 16), 23'h020000 + 23'(k));
      end
      ord = '{hw[0], aw[0], hw[1], aw[1], hw[2], aw[2]};
      hi = 0;
      ai = 0;
      for (int k = 0; k < 6; k++) begin
         setIn(1'b1, hi < 3, hw[hi < 3 ? hi : 0], ai < 3, aw[ai < 3 ? ai : 0], 1'b0, 1'b0);
         run(1'b0, dummy);
         hi += int'(gh);
         ai += int'(ga);
      end
      check("RrCount", Count, 5'd6);
      for (int k = 0; k < 6; k++) begin
         setIn(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
         run(1'b0, dummy);
         check("RrOrder", DecodeData, ord[k]);
      end

      // VBlank gating with a gap in the drain window.
      doReset();
      for (int k = 0; k < 4; k++) begin
         gw[k] = mk(4'hA, 8'(k + 40), 23'h030000 + 23'(k));
         setIn(1'b1, 1'b1, gw[k], 1'b0, '0, 1'b0, 1'b0);
         run(1'b0, dummy);
      end
      for (int k = 0; k < 10; k++) begin
         setIn(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
         run(1'b0, dummy);
         check("GateIdle", DecodeData, 35'd0);
      end
      setIn(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0); run(1'b0, dummy);
      check("GateE1", DecodeData, gw[0]);
      run(1'b0, dummy);
      check("GateE2", DecodeData, gw[1]);
      VBlank = 1'b0; run(1'b0, dummy);
      check("GateGap", DecodeData, 35'd0);
      VBlank = 1'b1; run(1'b0, dummy);
      check("GateE3", DecodeData, gw[2]);
      run(1'b0, dummy);
      check("GateE4", DecodeData, gw[3]);

      // Full, then pointer wrap under continuous push and pop.
      doReset();
      pushed.delete();
      popped.delete();
      for (int k = 0; k < 16; k++) begin
         setIn(1'b1, 1'b1, mk(4'hB, 8'(k), 23'(k)), 1'b0, '0, 1'b0, 1'b0);
         run(1'b0, dummy);
         if (gh) pushed.push_back(HostData);
      end
      setIn(1'b1, 1'b1, mk(4'hC, 8'd0, 23'd1), 1'b1, mk(4'hD, 8'd0, 23'd2), 1'b0, 1'b0);
      run(1'b0, dummy);
      check("FullHostReady", hrA, 1'b0);
      check("FullAnimReady", arA, 1'b0);
      check("FullCount", Count, 5'd16);
      for (int k = 0; k < 40; k++) begin
         setIn(1'b1, 1'b1, mk(4'hE, 8'(k + 100), 23'(k * 7)), 1'b0, '0, 1'b1, 1'b0);
         run(1'b0, dummy);
         if (gh) pushed.push_back(HostData);
         if (DecodeData != 35'd0) popped.push_back(DecodeData);
         check("WrapCountRange", (Count == 5'd15) || (Count == 5'd16), 1'b1);
      end
      for (int k = 0; k < 18; k++) begin
         setIn(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
         run(1'b0, dummy);
         if (DecodeData != 35'd0) popped.push_back(DecodeData);
      end
      check("WrapLen", popped.size(), pushed.size());
      for (int k = 0; k < pushed.size() && k < popped.size(); k++) begin
         check("WrapOrder", popped[k], pushed[k]);
      end

      // No-op filter.
      doReset();
      setIn(1'b1, 1'b1, nopw, 1'b0, '0, 1'b1, 1'b0); run(1'b0, dummy);
      check("NopReady", hrA, 1'b1);
      check("NopCount", Count, 5'd0);
      check("NopDec", DecodeData, 35'd0);
      HostData = w2; run(1'b0, dummy);
      check("Op1Ready", hrA, 1'b1);
      check("Op1Count", Count, 5'd1);
      HostValid = 1'b0; run(1'b0, dummy);
      check("Op1Dec", DecodeData, w2);

      // Flush wins over push and pop.
      doReset();
      for (int k = 0; k < 5; k++) begin
         setIn(1'b1, 1'b1, mk(4'h7, 8'(k), 23'(k + 9)), 1'b0, '0, 1'b0, 1'b0);
         run(1'b0, dummy);
      end
      setIn(1'b1, 1'b0, '0, 1'b1, w6, 1'b1, 1'b1); run(1'b0, dummy);
      check("FlushAnimReady", arA, 1'b0);
      check("FlushCount", Count, 5'd0);
      check("FlushDec", DecodeData, 35'd0);

      // Randomized traffic with bursty VBlank against the queue model.
      doReset();
      VBlank = 1'b0;
      for (int k = 0; k < 1500; k++) begin
         setIn(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 2) != 0), 35'({$urandom, $urandom}),
               ($urandom_range(0, 2) != 0), 35'({$urandom, $urandom}),
               ($urandom_range(0, 7) == 0) ? !VBlank : VBlank,
               ($urandom_range(0, 59) == 0));
         run(1'b0, dummy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_command_scheduler.md
# sprite_command_scheduler

Sequences GPU sprite commands into the sprite input decoder. Two requesters share the decoder's 35-bit command input: the host CPU port and the animation engine port. Accepted commands are arbitrated round-robin into a FIFO, then drained one per cycle only while vertical blanking is active, so sprite state never changes mid-frame. When nothing is issued, the output bus carries the all-zero no-op word, so the decoder asserts no write strobe.

## Interface
- DEPTH, 16, FIFO entries; power of two, at least 2
- ADDR_W, 4, log2(DEPTH)
- Clk  in  1  system clock; all logic on the rising edge
- ResetN  in  1  synchronous, active-low reset
- HostData  in  35  host command word: [34:31] opcode, [30:23] sprite index, [22:0] payload
- HostValid  in  1  HostData is valid
- HostReady  out  1  host word accepted on this edge
- AnimData  in  35  animation-engine command word, same format as HostData
- AnimValid  in  1  AnimData is valid
- AnimReady  out  1  animation word accepted on this edge
- VBlank  in  1  drain enable: high during vertical blanking
- Flush  in  1  discard all queued commands
- DecodeData  out  35  command to the decoder; all-zero when idle
- Count  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
- Busy  out  1  Count != 0

## Operation
- **Arbitration**
  - At most one push per cycle.
  - A requester is eligible when its Valid=1, the FIFO is not full, and Flush=0.
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, the one selected by the round-robin pointer is granted. The pointer then points to the other requester.
  - The pointer resets to Host.
  - A Ready signal is high only in the granted cycle. Ready is combinational from Valid, Count and Flush.
- **No-op filter**: a granted word with opcode 0 is accepted (Ready=1) but not written. It still advances the round-robin pointer.
- **Drain**
  - In any cycle with VBlank=1, Count>0 and Flush=0, the head entry is popped.
  - The popped entry is registered onto DecodeData.
  - Otherwise DecodeData is registered to 35'd0.
  - FIFO order is preserved across VBlank gaps.
- **Simultaneous push and pop**: both happen; Count is unchanged.
  - Push while full and pop in the same cycle: not allowed. Full status uses the pre-pop Count, so Ready=0.
  - Pop of an empty FIFO in the same cycle as a push: not allowed. The word is not visible until the next cycle.
- **Flush**: highest priority. On the edge where Flush=1:
  - read and write pointers and Count clear;
  - both Ready outputs are 0;
  - no pop occurs;
  - DecodeData is 0 on the following cycle.
- **Pointers**: ADDR_W bits, wrapping modulo DEPTH. Count is tracked separately, ADDR_W+1 bits wide.
- **Reset** (ResetN=0 at an edge):
  - DecodeData=0, Count=0, Busy=0, round-robin pointer=Host.
  - FIFO contents are don't-care.
  - HostReady=0 and AnimReady=0 while ResetN=0.
  - Reset mid-drain abandons queued commands.

## Timing
- Push: a word accepted at edge E0 occupies the FIFO from E0 onward.
- Minimum latency: a word accepted at edge E0 appears on DecodeData after edge E1, provided VBlank=1 during cycle E0..E1 and the word is at the head.
- Throughput: one push and one pop per cycle.
- DecodeData holds each command for exactly one cycle. Back-to-back pops produce consecutive non-zero words.
- VBlank falling: the pop decision uses VBlank in the current cycle. The first cycle with VBlank=0 registers zero onto DecodeData.
- Count and Busy are registered. They reflect the pushes and pops of the previous edge.

## Structure
- Shared package gpu_cmd_pkg holds:
  - CMD_W=35
  - OP_MSB=34, OP_LSB=31
  - IDX_MSB=30, IDX_LSB=23
  - PAY_MSB=22
  - OP_NOP=4'd0
  - decoder-side DATA_W=27
- Sub-module cmd_fifo: single-clock synchronous FIFO, parameterised by DEPTH and width.
  - Ports: push, pop, din, dout, count, full, empty, clear.
  - Arbitration, the no-op filter and drain gating stay in the top-level block.

## Test plan
- **Reset**: ResetN=0 for 3 cycles with HostValid=1 → DecodeData=0, Count=0, HostReady=0. After release, a host word with opcode 4'h2 and index 8'd5 is accepted on the next edge.
- **Round-robin**: both Valid=1 continuously, VBlank=0, 6 cycles, words H0..H2 and A0..A2 offered in order → FIFO order H0,A0,H1,A1,H2,A2. Count reaches 6.
- **VBlank gating**: 4 entries queued, VBlank=0 for 10 cycles → DecodeData stays 0. VBlank=1 for 2 cycles, then 0, then 1 → DecodeData shows entries 1 and 2, then 0, then entries 3 and 4 in order.
- **Full / wrap**: fill 16 entries → both Ready=0 and Count=16. Hold VBlank=1 with a new push every cycle for 40 cycles → pointers wrap, Count steady at DEPTH-1 or DEPTH, and the output sequence matches the input sequence with no loss.
- **No-op filter**: host sends opcode 0, then opcode 4'h1, with VBlank=1 → HostReady=1 both cycles, Count peaks at 1, and only the opcode-1 word appears on DecodeData.
- **Flush**: 5 entries queued, VBlank=1, Flush=1 with AnimValid=1 in the same cycle → AnimReady=0, no pop, Count=0 and DecodeData=0 on the next cycle.
